// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions used by the data-memory path.
//   - mem_state_e : data-memory controller FSM states (IDLE/BUSY/DONE)
//   - F3_*        : load/store funct3 size/sign encodings
//   - access_fault: misalignment / illegal-encoding check for one access
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  // Returns 1 when the access cannot be performed: halfwords must be
  // 2-byte aligned, words 4-byte aligned, and unknown encodings are illegal.
  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] off);
    logic flt;
    case (f3)
      F3_B, F3_BU: flt = 1'b0;
      F3_H, F3_HU: flt = off[0];
      F3_W:        flt = (off != 2'b00);
      default:     flt = 1'b1;
    endcase
    return flt;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH x 32-bit storage with per-byte write enables.
// Writes occur on the rising clock edge; reads are asynchronous.
// Contents are never reset.
// Ports:
//   clk   - clock
//   we    - write strobe
//   be    - byte-lane enables (bit i covers wdata[8*i+7:8*i])
//   addr  - word index, shared by read and write
//   wdata - lane-replicated write data
//   rdata - word currently stored at addr
module dmem_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_r [DEPTH];

  // Byte-lane write port
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: fixed-latency load/store controller in front of dmem_ram.
// A request seen in IDLE is latched and the pipeline is stalled until the
// DONE cycle, which falls exactly LATENCY cycles after the request cycle.
// Stores commit and loads return data during DONE.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   mem_read    - load request
//   mem_write   - store request (wins if both are high)
//   funct3      - access size/sign
//   addr        - byte address
//   wdata       - right-aligned store data
//   rdata       - extended load result, zero unless rvalid
//   rvalid      - load-complete strobe (DONE only)
//   stall       - pipeline freeze while a request is in flight
//   fault       - misaligned / illegal access strobe (DONE only)
module data_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        stall,
  output logic        fault
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  mem_state_e  state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [AW+1:0] addr_r;
  logic [31:0] wdata_r;
  logic [2:0]  funct3_r;
  logic        store_r;
  logic        load_r;

  logic        req_s;
  logic        done_s;
  logic        fault_s;
  logic        ram_we_s;
  logic [3:0]  be_s;
  logic [31:0] ram_wdata_s;
  logic [31:0] ram_rdata_s;
  logic [31:0] lane_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] ext_s;
  logic        unused_addr_s;

  // Address bits above the RAM window are deliberately ignored (wrap).
  assign unused_addr_s = ^addr[31:AW+2];

  assign req_s = mem_read | mem_write;

  // State, counter and request-latch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= '0;
      wdata_r  <= 32'd0;
      funct3_r <= 3'd0;
      store_r  <= 1'b0;
      load_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      // Inputs are only sampled on acceptance; later changes are ignored.
      if (state_r == IDLE && req_s) begin
        addr_r   <= addr[AW+1:0];
        wdata_r  <= wdata;
        funct3_r <= funct3;
        store_r  <= mem_write;
        load_r   <= mem_read & ~mem_write;
      end
    end
  end

  // Next-state, latency counter and stall
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    stall   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          stall = 1'b1;
          if (LATENCY == 1) begin
            state_s = DONE;
            cnt_s   = 4'd0;
          end else begin
            state_s = BUSY;
            cnt_s   = LAT_M1;
          end
        end else begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_s = cnt_r - 4'd1;
        // The counter reaches 0 on this edge: the next cycle is DONE.
        if (cnt_r <= 4'd1) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  assign done_s   = (state_r == DONE);
  assign fault_s  = access_fault(funct3_r, addr_r[1:0]);
  assign ram_we_s = done_s & store_r & ~fault_s;

  // Store lane enables and lane-replicated write data
  always_comb begin
    be_s        = 4'b0000;
    ram_wdata_s = wdata_r;
    case (funct3_r[1:0])
      2'b00: begin
        be_s        = 4'b0001 << addr_r[1:0];
        ram_wdata_s = {4{wdata_r[7:0]}};
      end
      2'b01: begin
        be_s        = addr_r[1] ? 4'b1100 : 4'b0011;
        ram_wdata_s = {2{wdata_r[15:0]}};
      end
      2'b10: begin
        be_s        = 4'b1111;
        ram_wdata_s = wdata_r;
      end
      default: begin
        be_s        = 4'b0000;
        ram_wdata_s = wdata_r;
      end
    endcase
  end

  dmem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .be    (be_s),
    .addr  (addr_r[AW+1:2]),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  assign lane_s = ram_rdata_s >> {addr_r[1:0], 3'b000};
  assign byte_s = lane_s[7:0];
  assign half_s = addr_r[1] ? ram_rdata_s[31:16] : ram_rdata_s[15:0];

  // Load lane selection and sign/zero extension
  always_comb begin
    ext_s = 32'd0;
    case (funct3_r)
      F3_B:    ext_s = {{24{byte_s[7]}}, byte_s};
      F3_BU:   ext_s = {24'd0, byte_s};
      F3_H:    ext_s = {{16{half_s[15]}}, half_s};
      F3_HU:   ext_s = {16'd0, half_s};
      F3_W:    ext_s = ram_rdata_s;
      default: ext_s = 32'd0;
    endcase
  end

  // Completion outputs decode only registered state, so reset clears them at once.
  assign rvalid = done_s & load_r & ~fault_s;
  assign fault  = done_s & fault_s;
  assign rdata  = rvalid ? ext_s : 32'd0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl
// (DEPTH=256, LATENCY=2). Inputs are driven on the falling edge and outputs
// are sampled 1 time unit later, away from the rising (active) edge.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        stall;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  data_mem_ctrl #(
    .DEPTH   (256),
    .LATENCY (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .stall     (stall),
    .fault     (fault)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One complete request with cycle-exact checks for LATENCY=2:
  // request cycle (IDLE), BUSY, DONE, then back in IDLE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic exp_rv,
                        input logic exp_flt, input logic [31:0] exp_rd);
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    #1;
    chk({tag, "_stall_req"}, 32'(stall), 32'd1);
    chk({tag, "_rvalid_req"}, 32'(rvalid), 32'd0);
    @(negedge clk);
    // Scramble the inputs while busy; only the latched copies may be used.
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b111;
    addr      = 32'hFFFF_FFFF;
    wdata     = 32'hA5A5_A5A5;
    #1;
    chk({tag, "_stall_busy"}, 32'(stall), 32'd1);
    chk({tag, "_rvalid_busy"}, 32'(rvalid), 32'd0);
    chk({tag, "_fault_busy"}, 32'(fault), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    chk({tag, "_rvalid_done"}, 32'(rvalid), 32'(exp_rv));
    chk({tag, "_fault_done"}, 32'(fault), 32'(exp_flt));
    chk({tag, "_rdata_done"}, rdata, exp_rd);
    @(negedge clk);
    funct3 = 3'b000;
    addr   = 32'd0;
    wdata  = 32'd0;
    #1;
    chk({tag, "_stall_after"}, 32'(stall), 32'd0);
    chk({tag, "_rvalid_after"}, 32'(rvalid), 32'd0);
    chk({tag, "_fault_after"}, 32'(fault), 32'd0);
    chk({tag, "_rdata_after"}, rdata, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = 32'd0;
    wdata     = 32'd0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic word store / load
    access("sw10", 1'b0, 1'b1, LW, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    access("lw10", 1'b1, 1'b0, LW, 32'h10, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);

    // Byte store into lane 3, then signed / unsigned byte loads
    access("sb13", 1'b0, 1'b1, LB, 32'h13, 32'h00000081, 1'b0, 1'b0, 32'd0);
    access("lb13", 1'b1, 1'b0, LB, 32'h13, 32'd0, 1'b1, 1'b0, 32'hFFFFFF81);
    access("lbu13", 1'b1, 1'b0, LBU, 32'h13, 32'd0, 1'b1, 1'b0, 32'h00000081);
    access("lw10_sb", 1'b1, 1'b0, LW, 32'h10, 32'd0, 1'b1, 1'b0, 32'h81ADBEEF);

    // Other lane / halfword selections from word 0x81ADBEEF
    access("lh12", 1'b1, 1'b0, LH, 32'h12, 32'd0, 1'b1, 1'b0, 32'hFFFF81AD);
    access("lhu10", 1'b1, 1'b0, LHU, 32'h10, 32'd0, 1'b1, 1'b0, 32'h0000BEEF);
    access("lb11", 1'b1, 1'b0, LB, 32'h11, 32'd0, 1'b1, 1'b0, 32'hFFFFFFBE);
    access("lbu12", 1'b1, 1'b0, LBU, 32'h12, 32'd0, 1'b1, 1'b0, 32'h000000AD);

    // Halfword store into the upper half of word 0x14
    access("sw14", 1'b0, 1'b1, LW, 32'h14, 32'h00000000, 1'b0, 1'b0, 32'd0);
    access("sh16", 1'b0, 1'b1, LH, 32'h16, 32'h0000ABCD, 1'b0, 1'b0, 32'd0);
    access("lw14", 1'b1, 1'b0, LW, 32'h14, 32'd0, 1'b1, 1'b0, 32'hABCD0000);
    access("lh16", 1'b1, 1'b0, LH, 32'h16, 32'd0, 1'b1, 1'b0, 32'hFFFFABCD);

    // Misaligned load faults, then a normal load completes
    access("lw12_flt", 1'b1, 1'b0, LW, 32'h12, 32'd0, 1'b0, 1'b1, 32'd0);
    access("lw10_post", 1'b1, 1'b0, LW, 32'h10, 32'd0, 1'b1, 1'b0, 32'h81ADBEEF);
    access("lh11_flt", 1'b1, 1'b0, LH, 32'h11, 32'd0, 1'b0, 1'b1, 32'd0);
    access("f3_011_flt", 1'b1, 1'b0, 3'b011, 32'h10, 32'd0, 1'b0, 1'b1, 32'd0);

    // Read and write together act as a store
    access("rw20", 1'b1, 1'b1, LW, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'd0);
    access("lw20", 1'b1, 1'b0, LW, 32'h20, 32'd0, 1'b1, 1'b0, 32'h12345678);

    // Faulting stores must not write
    access("sw21_flt", 1'b0, 1'b1, LW, 32'h21, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0);
    access("sh23_flt", 1'b0, 1'b1, LH, 32'h23, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0);
    access("lw20_kept", 1'b1, 1'b0, LW, 32'h20, 32'd0, 1'b1, 1'b0, 32'h12345678);

    // Address wrap modulo DEPTH*4 = 0x400
    access("lw410", 1'b1, 1'b0, LW, 32'h410, 32'd0, 1'b1, 1'b0, 32'h81ADBEEF);
    access("sw810", 1'b0, 1'b1, LW, 32'h810, 32'h55AA55AA, 1'b0, 1'b0, 32'd0);
    access("lw10_wrap", 1'b1, 1'b0, LW, 32'h10, 32'd0, 1'b1, 1'b0, 32'h55AA55AA);

    // Reset while BUSY drops the in-flight store
    access("sw30", 1'b0, 1'b1, LW, 32'h30, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    mem_write = 1'b1;
    funct3    = LW;
    addr      = 32'h30;
    wdata     = 32'h11111111;
    #1;
    chk("rstmid_stall_req", 32'(stall), 32'd1);
    @(negedge clk);
    mem_write = 1'b0;
    #1;
    chk("rstmid_stall_busy", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_stall", 32'(stall), 32'd0);
    chk("rstmid_rvalid", 32'(rvalid), 32'd0);
    chk("rstmid_fault", 32'(fault), 32'd0);
    chk("rstmid_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmid_stall_rel", 32'(stall), 32'd0);
    access("lw30_old", 1'b1, 1'b0, LW, 32'h30, 32'd0, 1'b1, 1'b0, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the number of 32-bit words of storage.
REQ-002 SHALL have parameter LATENCY, default 2, giving request-to-completion cycles; legal range 1..15.
REQ-003 SHALL have ports, in this order: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have mem_read  in  1  load request from the decode/control path.
REQ-006 SHALL have mem_write  in  1  store request from the decode/control path.
REQ-007 SHALL have funct3  in  3  access size/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-008 SHALL have addr  in  32  byte address, ALU ADD result.
REQ-009 SHALL have wdata  in  32  store data, right-aligned.
REQ-010 SHALL have rdata  out  32  load result, sign- or zero-extended.
REQ-011 SHALL have rvalid  out  1  one-cycle load-complete strobe.
REQ-012 SHALL have stall  out  1  pipeline freeze while a request is in flight.
REQ-013 SHALL have fault  out  1  one-cycle strobe for a misaligned or illegal-funct3 access.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL enter BUSY from IDLE when mem_read or mem_write is high, latching addr, wdata, funct3 and the request type.
REQ-016 SHALL drive stall combinationally high in IDLE while a request is present, high throughout BUSY, and low in DONE.
REQ-017 SHALL load a down-counter with LATENCY-1 on BUSY entry and move to DONE when it reaches 0; if LATENCY=1, SHALL go from IDLE directly to DONE.
REQ-018 SHALL place DONE exactly LATENCY cycles after the request cycle, and SHALL always return from DONE to IDLE.
REQ-019 SHALL NOT accept a request in DONE; the pipeline advances at the end of DONE.
REQ-020 SHALL treat mem_read and mem_write both high as a store; the load is discarded and rvalid stays low.
REQ-021 SHALL commit stores to the RAM in DONE using byte enables: SB writes one lane at addr[1:0], SH two lanes at addr[1], SW all four lanes.
REQ-022 SHALL, for loads in DONE, assert rvalid=1 and drive rdata from the selected lane(s): LB/LH sign-extended, LBU/LHU zero-extended, LW whole word.
REQ-023 SHALL hold rdata at 0 whenever rvalid is low.
REQ-024 SHALL map the word index as addr[log2(DEPTH)+1:2], so higher address bits are ignored and addresses wrap modulo DEPTH*4.
REQ-025 SHALL treat LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, and any funct3 not listed in REQ-007 as a fault.
REQ-026 SHALL, on a fault, pulse fault=1 in DONE, perform no RAM write, and keep rvalid=0 and rdata=0.
REQ-027 SHALL ignore request inputs outside IDLE; only the latched copies are used.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-request, force state=IDLE, counter=0, stall=0, rvalid=0, fault=0 and rdata=0.
REQ-029 SHALL drop any in-flight request on reset, with no RAM write.
REQ-030 SHALL leave RAM contents undefined after reset; RAM contents are not cleared.

Structure
REQ-031 SHALL take the funct3 encodings and the state enum (IDLE/BUSY/DONE) from shared package cpu_pkg.
REQ-032 SHALL contain one sub-module, dmem_ram: a synchronous-write, asynchronous-read, byte-enable RAM of DEPTH x 32.
REQ-033 SHALL keep lane selection, extension and fault logic in data_mem_ctrl.

Verification
REQ-034 SHALL cover: SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 (LATENCY=2) -> stall high for 2 cycles, rvalid in cycle 2, rdata=0xDEADBEEF.
REQ-035 SHALL cover: SB 0x81 at addr=0x13, then LB 0x13 -> rdata=0xFFFFFF81; LBU 0x13 -> rdata=0x00000081; other lanes of word 0x10 unchanged.
REQ-036 SHALL cover: LW addr=0x12 -> fault pulse in DONE, rvalid=0, rdata=0; following LW 0x10 completes normally.
REQ-037 SHALL cover: mem_read and mem_write both high with wdata=0x12345678 at 0x20 -> rvalid=0; later LW 0x20 returns 0x12345678.
REQ-038 SHALL cover: rst_n low in BUSY during an SW to 0x30 -> stall=0 immediately; LW 0x30 after reset shows the old contents unchanged.
REQ-039 SHALL cover: addr=0x400+0x10 with DEPTH=256 -> same word as 0x10 (wrap).
